s247_core_scheduler: RTL

Parametrised run controller for the compute-core array. It replaces a free-running enable-mask register with a start/abort/halt state machine. It adds per-run completion tracking, a watchdog timeout, a sticky emergency-halt latch with explicit clear, a run-cycle counter and a maskable interrupt. It sits between the register bus and the `NUM_CORES` compute cores, and drives their enable and soft-clear.

---
 rtl/s247_core_scheduler.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/s247_core_scheduler.sv
// s247_core_scheduler
// Run controller for the compute-core array. It handles start/abort/halt
// sequencing, per-run completion tracking, the watchdog, the sticky emergency
// halt latch, the run-cycle counter and a maskable level interrupt.
//
// Register handshake: a request is accepted on any cycle where reg_valid is
// high and reg_ack is low. reg_ack rises on the following cycle for exactly
// one cycle. For a read, reg_rdata carries the data in that same cycle and is
// 0 otherwise. A request still held while ack is high is not taken again
// until the cycle after ack drops.
module s247_core_scheduler #(
    parameter int NUM_CORES = 8,
    parameter int WDT_WIDTH = 24,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reg_valid,
    input  logic                 reg_we,
    input  logic [3:0]           reg_addr,
    input  logic [31:0]          reg_wdata,
    output logic                 reg_ack,
    output logic [31:0]          reg_rdata,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic [NUM_CORES-1:0] core_halt,
    output logic [NUM_CORES-1:0] core_enable,
    output logic                 core_clear,
    output logic                 irq,
    output logic                 busy,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_COMPLETE = 2'd2,
        ST_HALTED   = 2'd3
    } state_t;

    localparam logic [3:0] ADDR_CTRL     = 4'd0;
    localparam logic [3:0] ADDR_MASK     = 4'd1;
    localparam logic [3:0] ADDR_TIMEOUT  = 4'd2;
    localparam logic [3:0] ADDR_STATUS   = 4'd3;
    localparam logic [3:0] ADDR_DONE     = 4'd4;
    localparam logic [3:0] ADDR_HALT     = 4'd5;
    localparam logic [3:0] ADDR_CYCLES   = 4'd6;
    localparam logic [3:0] ADDR_IRQ_EN   = 4'd7;
    localparam logic [3:0] ADDR_IRQ_STAT = 4'd8;

    state_t                 state_q, next_state;
    logic [NUM_CORES-1:0]   mask_q;
    logic [WDT_WIDTH-1:0]   timeout_q;
    logic [WDT_WIDTH-1:0]   wdt_q;
    logic [NUM_CORES-1:0]   active_mask_q;
    logic [NUM_CORES-1:0]   done_vec_q;
    logic [NUM_CORES-1:0]   halt_vec_q;
    logic [CNT_WIDTH-1:0]   run_cycles_q;
    logic [2:0]             irq_en_q;
    logic [2:0]             irq_stat_q;
    logic                   timeout_flag_q;
    logic                   halt_latched_q;

    // Bus decode
    logic                   acc, wr, rd;
    logic                   cmd_start, cmd_abort, cmd_halt_clr;
    logic [2:0]             w1c_bits;
    logic [2:0]             irq_en_next;
    logic [2:0]             irq_stat_next;
    logic [NUM_CORES-1:0]   done_next;
    logic                   wdt_expire;
    logic                   take_halt, take_timeout, take_abort;
    logic                   take_complete, take_start, take_halt_clr;
    logic [31:0]            rd_mux;
    logic [31:0]            mask_ext, timeout_ext, done_ext, halt_ext, cycles_ext;
    logic                   unused_wdata;

    assign acc          = reg_valid && !reg_ack;
    assign wr           = acc && reg_we;
    assign rd           = acc && !reg_we;
    assign cmd_start    = wr && (reg_addr == ADDR_CTRL) && reg_wdata[0];
    assign cmd_abort    = wr && (reg_addr == ADDR_CTRL) && reg_wdata[1];
    assign cmd_halt_clr = wr && (reg_addr == ADDR_CTRL) && reg_wdata[2];
    assign unused_wdata = ^reg_wdata;

    assign done_next  = done_vec_q | (core_done & active_mask_q);
    // The watchdog fires on the cycle the counter would step from 1 to 0.
    assign wdt_expire = (timeout_q != '0) && (wdt_q == WDT_WIDTH'(1));

    // A hardware set beats a software W1C of the same bit.
    assign w1c_bits      = (wr && reg_addr == ADDR_IRQ_STAT) ? reg_wdata[2:0] : 3'b000;
    assign irq_stat_next = (irq_stat_q & ~w1c_bits) | {take_timeout, take_halt, take_complete};
    assign irq_en_next   = (wr && reg_addr == ADDR_IRQ_EN) ? reg_wdata[2:0] : irq_en_q;

    assign state_dbg = state_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= next_state;
    end

    // Next-state selection with priority halt > timeout > abort > completion > start
    always_comb begin
        next_state    = state_q;
        take_halt     = 1'b0;
        take_timeout  = 1'b0;
        take_abort    = 1'b0;
        take_complete = 1'b0;
        take_start    = 1'b0;
        take_halt_clr = 1'b0;
        if ((|core_halt) && (state_q != ST_HALTED)) begin
            take_halt  = 1'b1;
            next_state = ST_HALTED;
        end else begin
            case (state_q)
                ST_IDLE, ST_COMPLETE: begin
                    if (cmd_start && (mask_q != '0)) begin
                        take_start = 1'b1;
                        next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (wdt_expire) begin
                        take_timeout = 1'b1;
                        next_state   = ST_HALTED;
                    end else if (cmd_abort) begin
                        take_abort = 1'b1;
                        next_state = ST_IDLE;
                    end else if (done_next == active_mask_q) begin
                        take_complete = 1'b1;
                        next_state    = ST_COMPLETE;
                    end
                end
                ST_HALTED: begin
                    if (cmd_halt_clr && (core_halt == '0)) begin
                        take_halt_clr = 1'b1;
                        next_state    = ST_IDLE;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Read data selection, narrow registers zero-extended to the bus width
    always_comb begin
        mask_ext    = '0;
        timeout_ext = '0;
        done_ext    = '0;
        halt_ext    = '0;
        cycles_ext  = '0;
        rd_mux      = 32'hDEAD_BEEF;
        mask_ext[NUM_CORES-1:0]    = mask_q;
        timeout_ext[WDT_WIDTH-1:0] = timeout_q;
        done_ext[NUM_CORES-1:0]    = done_vec_q;
        halt_ext[NUM_CORES-1:0]    = halt_vec_q;
        cycles_ext[CNT_WIDTH-1:0]  = run_cycles_q;
        case (reg_addr)
            ADDR_CTRL:     rd_mux = 32'h0;
            ADDR_MASK:     rd_mux = mask_ext;
            ADDR_TIMEOUT:  rd_mux = timeout_ext;
            ADDR_STATUS:   rd_mux = {28'd0, halt_latched_q, timeout_flag_q, state_q};
            ADDR_DONE:     rd_mux = done_ext;
            ADDR_HALT:     rd_mux = halt_ext;
            ADDR_CYCLES:   rd_mux = cycles_ext;
            ADDR_IRQ_EN:   rd_mux = {29'd0, irq_en_q};
            ADDR_IRQ_STAT: rd_mux = {29'd0, irq_stat_q};
            default:       rd_mux = 32'hDEAD_BEEF;
        endcase
    end

    // Bus acknowledge and registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_ack   <= 1'b0;
            reg_rdata <= '0;
        end else begin
            reg_ack   <= acc;
            reg_rdata <= rd ? rd_mux : 32'h0;
        end
    end

    // Software-writable configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q    <= '1;
            timeout_q <= '0;
            irq_en_q  <= '0;
        end else begin
            if (wr && reg_addr == ADDR_MASK)    mask_q    <= reg_wdata[NUM_CORES-1:0];
            if (wr && reg_addr == ADDR_TIMEOUT) timeout_q <= reg_wdata[WDT_WIDTH-1:0];
            irq_en_q <= irq_en_next;
        end
    end

    // Per-run tracking: active mask, done accumulation, cycle count, watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_mask_q <= '0;
            done_vec_q    <= '0;
            run_cycles_q  <= '0;
            wdt_q         <= '0;
        end else if (take_start) begin
            active_mask_q <= mask_q;
            done_vec_q    <= '0;
            run_cycles_q  <= '0;
            wdt_q         <= timeout_q;
        end else if (state_q == ST_RUN) begin
            done_vec_q <= done_next;
            if (run_cycles_q != '1) run_cycles_q <= run_cycles_q + 1'b1;
            if ((timeout_q != '0) && (wdt_q != '0)) wdt_q <= wdt_q - 1'b1;
        end
    end

    // Halt capture, sticky halt latch and timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_vec_q     <= '0;
            halt_latched_q <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else if (take_halt) begin
            halt_vec_q     <= core_halt;
            halt_latched_q <= 1'b1;
        end else if (take_halt_clr) begin
            halt_vec_q     <= '0;
            halt_latched_q <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else if (take_timeout) begin
            timeout_flag_q <= 1'b1;
        end else if (take_start) begin
            timeout_flag_q <= 1'b0;
        end else if (state_q == ST_HALTED) begin
            halt_vec_q <= halt_vec_q | core_halt;
        end
    end

    // Interrupt status and registered core-facing outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_stat_q  <= '0;
            irq         <= 1'b0;
            core_enable <= '0;
            core_clear  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            irq_stat_q  <= irq_stat_next;
            irq         <= |(irq_stat_next & irq_en_next);
            core_enable <= (next_state == ST_RUN) ? (take_start ? mask_q : active_mask_q) : '0;
            core_clear  <= take_abort || take_halt_clr;
            busy        <= (next_state == ST_RUN);
        end
    end

endmodule
